// File: rtl/spr_line_engine.sv
// spr_line_engine
//
// Sprite line engine. On a start pulse it scans the sprite attribute table
// held in VRAM, selects the sprites that cover the requested line (up to
// MAX_PER_LINE of them), fetches each sprite's pattern row and writes its
// opaque pixels into an external 256-entry line buffer. A 256-bit occupancy
// mask gives the lower-indexed sprite priority and flags collisions.
//
// Ports
//   clk, reset       clock (rising edge) and asynchronous active-high reset
//   start            one-cycle pulse: (re)start evaluation of 'line'
//   line             line number being prepared
//   base_sprattr     attribute table base, VRAM word address bits [12:7]
//   base_sprpat      pattern table base, VRAM word address bit [12]
//   spr_h16          8x16 sprites when 1, 8x8 when 0
//   spr_zoom         doubles sprite width and height
//   spr_shift        moves every sprite 8 pixels left
//   vaddr            registered VRAM word address
//   vdata            VRAM data for the address presented in the previous cycle
//   wr_idx/wr_data   line buffer pixel index / 4-bit colour
//   wr_en            line buffer write strobe
//   busy             high while a line is being evaluated
//   done             one-cycle pulse on return to IDLE
//   spr_overflow     one-cycle pulse when too many sprites hit the line
//   spr_collision    one-cycle pulse per opaque pixel landing on an occupied one
//   dbg_state_o      current FSM state, for observation only
//
// Handshake: start is a fire-and-forget pulse with no ready. It is accepted in
// any state, aborts whatever is in progress and restarts the scan; the caller
// watches done (or busy falling) to know the line is complete. VRAM has a
// fixed one-cycle read latency, so no valid/ready is needed on that side.
module spr_line_engine #(
  parameter int NUM_SPR      = 64,
  parameter int MAX_PER_LINE = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  line,
  input  logic [5:0]  base_sprattr,
  input  logic        base_sprpat,
  input  logic        spr_h16,
  input  logic        spr_zoom,
  input  logic        spr_shift,
  output logic [12:0] vaddr,
  input  logic [15:0] vdata,
  output logic [7:0]  wr_idx,
  output logic [3:0]  wr_data,
  output logic        wr_en,
  output logic        busy,
  output logic        done,
  output logic        spr_overflow,
  output logic        spr_collision,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_Y_ADDR = 3'd1,
    S_Y_CHK  = 3'd2,
    S_XN     = 3'd3,
    S_PAT0   = 3'd4,
    S_PAT1   = 3'd5,
    S_DRAW   = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    idx_q, idx_d;        // reaches NUM_SPR (64) to end the scan
  logic [4:0]    hit_q, hit_d;
  logic [255:0]  occ_q, occ_d;
  logic [3:0]    row_q, row_d;
  logic [7:0]    x_q, x_d;
  logic [7:0]    p0_q, p0_d, p1_q, p1_d, p2_q, p2_d, p3_q, p3_d;
  logic [4:0]    pix_q, pix_d;
  logic [12:0]   vaddr_q, vaddr_d;
  logic [7:0]    wr_idx_q, wr_idx_d;
  logic [3:0]    wr_data_q, wr_data_d;
  logic          wr_en_q, wr_en_d;
  logic          done_q, done_d;
  logic          ovf_q, ovf_d;
  logic          coll_q, coll_d;

  // Datapath helpers
  logic [7:0] y_val;
  logic [7:0] ydiff;
  logic [7:0] height;
  logic       on_line;
  logic [3:0] row;
  logic [4:0] width_m1;
  logic [2:0] bit_sel;
  logic [3:0] colour;
  logic [9:0] pos;
  logic       pos_ok;

  always_comb begin
    // Two Y bytes share one attribute word; idx[0] picks the half.
    y_val  = idx_q[0] ? vdata[15:8] : vdata[7:0];
    // Sprites are displayed starting one line below their Y value.
    ydiff  = line - (y_val + 8'd1);
    height = spr_h16 ? (spr_zoom ? 8'd32 : 8'd16) : (spr_zoom ? 8'd16 : 8'd8);
    on_line = (ydiff < height);
    row    = spr_zoom ? ydiff[4:1] : ydiff[3:0];
    width_m1 = spr_zoom ? 5'd15 : 5'd7;
    // Leftmost pixel is bit 7; with zoom each bit is shown twice.
    bit_sel = 3'd7 - (spr_zoom ? pix_q[3:1] : pix_q[2:0]);
    colour  = {p3_q[bit_sel], p2_q[bit_sel], p1_q[bit_sel], p0_q[bit_sel]};
    // 10-bit arithmetic so that shifted-off-left pixels become negative.
    pos     = {2'b00, x_q} + {5'b00000, pix_q} - (spr_shift ? 10'd8 : 10'd0);
    pos_ok  = (pos[9:8] == 2'b00);
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hit_d     = hit_q;
    occ_d     = occ_q;
    row_d     = row_q;
    x_d       = x_q;
    p0_d      = p0_q;
    p1_d      = p1_q;
    p2_d      = p2_q;
    p3_d      = p3_q;
    pix_d     = pix_q;
    vaddr_d   = vaddr_q;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    wr_en_d   = 1'b0;
    done_d    = 1'b0;
    ovf_d     = 1'b0;
    coll_d    = 1'b0;

    if (start) begin
      state_d = S_Y_ADDR;
      idx_d   = 7'd0;
      hit_d   = 5'd0;
      occ_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
        end
        S_Y_ADDR: begin
          vaddr_d = {base_sprattr, 2'b00, idx_q[5:1]};
          state_d = S_Y_CHK;
        end
        S_Y_CHK: begin
          if (y_val == 8'hD0 || idx_q == 7'(NUM_SPR)) begin
            state_d = S_IDLE;
          end else if (!on_line) begin
            idx_d   = idx_q + 7'd1;
            state_d = S_Y_ADDR;
          end else if (hit_q == 5'(MAX_PER_LINE)) begin
            ovf_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            hit_d   = hit_q + 5'd1;
            row_d   = row;
            vaddr_d = {base_sprattr, 1'b1, idx_q[5:0]};
            state_d = S_XN;
          end
        end
        S_XN: begin
          x_d = vdata[7:0];
          // Tall sprites use an even/odd tile pair; row[3] selects the half.
          vaddr_d = {base_sprpat, vdata[15:9], (spr_h16 ? row_q[3] : vdata[8]),
                     row_q[2:0], 1'b0};
          state_d = S_PAT0;
        end
        S_PAT0: begin
          p0_d    = vdata[7:0];
          p1_d    = vdata[15:8];
          vaddr_d = {vaddr_q[12:1], 1'b1};
          state_d = S_PAT1;
        end
        S_PAT1: begin
          p2_d    = vdata[7:0];
          p3_d    = vdata[15:8];
          pix_d   = 5'd0;
          state_d = S_DRAW;
        end
        S_DRAW: begin
          if (colour != 4'd0 && pos_ok) begin
            if (occ_q[pos[7:0]]) begin
              coll_d = 1'b1;
            end else begin
              wr_en_d   = 1'b1;
              wr_idx_d  = pos[7:0];
              wr_data_d = colour;
              occ_d[pos[7:0]] = 1'b1;
            end
          end
          if (pix_q == width_m1) begin
            idx_d   = idx_q + 7'd1;
            state_d = S_Y_ADDR;
          end else begin
            pix_d = pix_q + 5'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_IDLE && state_q != S_IDLE) done_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 7'd0;
      hit_q     <= 5'd0;
      occ_q     <= '0;
      row_q     <= 4'd0;
      x_q       <= 8'd0;
      p0_q      <= 8'd0;
      p1_q      <= 8'd0;
      p2_q      <= 8'd0;
      p3_q      <= 8'd0;
      pix_q     <= 5'd0;
      vaddr_q   <= 13'd0;
      wr_idx_q  <= 8'd0;
      wr_data_q <= 4'd0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      occ_q     <= occ_d;
      row_q     <= row_d;
      x_q       <= x_d;
      p0_q      <= p0_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      p3_q      <= p3_d;
      pix_q     <= pix_d;
      vaddr_q   <= vaddr_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      wr_en_q   <= wr_en_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      coll_q    <= coll_d;
    end
  end

  assign vaddr         = vaddr_q;
  assign wr_idx        = wr_idx_q;
  assign wr_data       = wr_data_q;
  assign wr_en         = wr_en_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign spr_overflow  = ovf_q;
  assign spr_collision = coll_q;
  assign dbg_state_o   = state_q;

endmodule

// File: doc/spr_line_engine.md
SPR_LINE_ENGINE -- requirements
Module: spr_line_engine

Interface
REQ-001 Parameter NUM_SPR, default 64, meaning sprite attribute entries scanned per line (1..64).
REQ-002 Parameter MAX_PER_LINE, default 8, meaning sprites drawn per line before overflow (1..16).
REQ-003 clk  input  1  clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  one-cycle pulse that begins evaluation of line.
REQ-006 line  input  8  line number being prepared.
REQ-007 base_sprattr  input  6  attribute table base, VRAM word address bits [12:7].
REQ-008 base_sprpat  input  1  pattern base, VRAM word address bit [12].
REQ-009 spr_h16  input  1  8x16 sprites when 1, 8x8 when 0.
REQ-010 spr_zoom  input  1  doubles sprite width and height when 1.
REQ-011 spr_shift  input  1  subtracts 8 from every sprite X when 1.
REQ-012 vaddr  output  13  VRAM word address, registered.
REQ-013 vdata  input  16  VRAM data for the vaddr of the previous cycle.
REQ-014 wr_idx  output  8  line buffer pixel index.
REQ-015 wr_data  output  4  sprite colour index (sprite palette implied).
REQ-016 wr_en  output  1  line buffer write strobe.
REQ-017 busy  output  1  high from the cycle after start until return to IDLE.
REQ-018 done  output  1  one-cycle pulse on return to IDLE.
REQ-019 spr_overflow  output  1  one-cycle pulse when more than MAX_PER_LINE sprites hit line.
REQ-020 spr_collision  output  1  one-cycle pulse when an opaque pixel hits an occupied position.

Function
REQ-021 States: IDLE, Y_ADDR, Y_CHK, XN, PAT0, PAT1, DRAW; start in any state aborts the current work, clears the sprite index, the hit count and the 256-bit occupancy mask, and enters Y_ADDR.
REQ-022 Y_ADDR drives {base_sprattr,2'b00,idx[5:1]}; Y_CHK takes Y from vdata[15:8] if idx[0] else vdata[7:0].
REQ-023 Y_CHK: Y==8'hD0 -> IDLE (terminator); idx==NUM_SPR -> IDLE; otherwise compute ydiff=line-(Y+1) mod 256.
REQ-024 Height H=(spr_h16?16:8)<<spr_zoom; sprite on line when ydiff<H; row=ydiff>>spr_zoom.
REQ-025 Off-line sprite: idx+1, back to Y_ADDR (2 cycles per skipped sprite).
REQ-026 On-line sprite with hit count==MAX_PER_LINE: pulse spr_overflow, go to IDLE; else increment hit count, drive {base_sprattr,1'b1,idx[5:0]}, go to XN.
REQ-027 XN latches X=vdata[7:0] and tile=vdata[15:8], then drives the pattern word {base_sprpat,tile[7:1],spr_h16?row[3]:tile[0],row[2:0],1'b0}.
REQ-028 PAT0 latches planes 0/1 (low/high byte) and sets vaddr[0]=1; PAT1 latches planes 2/3 likewise.
REQ-029 DRAW emits one pixel per cycle, W=8<<spr_zoom cycles; pixel i uses bit 7-(i>>spr_zoom) of each plane; colour={p3,p2,p1,p0}.
REQ-030 Pixel position pos=X+i-(spr_shift?8:0), computed 10-bit signed; pos<0 or pos>255 gives no write.
REQ-031 Colour 0 is transparent: no write, no occupancy change.
REQ-032 Opaque pixel at a free position: wr_en=1, wr_idx=pos, wr_data=colour, occupancy bit set.
REQ-033 Opaque pixel at an occupied position: no write, spr_collision pulse (lower index wins).
REQ-034 After DRAW, idx+1 and return to Y_ADDR.
REQ-035 Idle behaviour: outputs hold, vaddr holds its last value, wr_en=0.

Reset
REQ-036 Reset forces IDLE: vaddr=0, wr_idx=0, wr_data=0, wr_en=0, busy=0, done=0, spr_overflow=0, spr_collision=0, occupancy clear.
REQ-037 Reset asserted mid-line abandons the line with no further writes; the next start behaves as a first start.

Verification
REQ-038 Bench: sprite 0 Y=9, X=20, 8x8, colour 5 in all pixels, line=10 -> 8 writes idx 20..27 data 5, done pulse, no other flags.
REQ-039 Bench: 10 sprites on line, MAX_PER_LINE=8 -> 8 sprites drawn, spr_overflow pulses once, done follows.
REQ-040 Bench: sprites 0 and 1 overlap at X=100/104, both opaque -> positions 104..107 keep sprite 0 colour, spr_collision pulses 4 times.
REQ-041 Bench: spr_zoom=1, X=250 -> 16 pixels, each pattern bit doubled, only positions 250..255 written.
REQ-042 Bench: spr_shift=1, X=4 -> positions 0..3 written (pixels 4..7); sprite 2 Y=D0 -> scan stops, sprites 3+ ignored.
REQ-043 Bench: reset during DRAW -> wr_en low immediately, busy=0; the next start redraws the line correctly.
